// File: rtl/hybrid_banked_pq.sv
// hybrid_banked_pq: banked sorted-register priority queue.
// NUM_BANKS sorted banks, each with its best key at index 0, feed a combinational
// level-0 selector that picks the overall best head. Enqueue, dequeue and replace
// each complete in one cycle. MAX_MODE selects largest-first or smallest-first.
// Optional feature macro: HPQ_ERR_EN adds the sticky o_err[1:0] flags
// ([0] dropped enqueue on full, [1] ignored dequeue on empty).
module hybrid_banked_pq #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_BANKS  = 4,
  parameter int unsigned BANK_DEPTH = 8,
  parameter int unsigned MAX_MODE   = 1,
  localparam int unsigned QUEUE_SIZE = NUM_BANKS * BANK_DEPTH,
  localparam int unsigned SW         = $clog2(QUEUE_SIZE + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_wrt,
  input  logic                  i_read,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [SW-1:0]         o_size
`ifdef HPQ_ERR_EN
  ,
  output logic [1:0]            o_err
`endif
);

  localparam int unsigned CW = $clog2(BANK_DEPTH + 1);
  localparam int unsigned BW = $clog2(NUM_BANKS);

  logic [DATA_WIDTH-1:0] ent_q [NUM_BANKS][BANK_DEPTH];
  logic [DATA_WIDTH-1:0] ent_d [NUM_BANKS][BANK_DEPTH];
  logic [CW-1:0]         cnt_q [NUM_BANKS];
  logic [CW-1:0]         cnt_d [NUM_BANKS];
  logic [SW-1:0]         size_q;
  logic [SW-1:0]         size_d;

  logic [BW-1:0]         win;
  logic                  win_vld;
  logic [DATA_WIDTH-1:0] win_key;
  logic [BW-1:0]         tgt;
  logic                  tgt_vld;
  logic [CW-1:0]         tgt_cnt;

  logic                  full;
  logic                  empty;
  logic                  do_deq;
  logic                  do_rep;
  logic                  ins_new;

  logic [DATA_WIDTH-1:0] base [BANK_DEPTH];
  logic [CW-1:0]         base_cnt;
  logic                  shift;
  logic                  ins;
  logic                  ge;
  logic                  prev_ge;
  logic [DATA_WIDTH-1:0] prev_val;

  // Strictly better: used where the earlier candidate must win ties.
  function automatic logic better(input logic [DATA_WIDTH-1:0] a,
                                  input logic [DATA_WIDTH-1:0] b);
    return (MAX_MODE != 0) ? (a > b) : (a < b);
  endfunction

  // Better or equal: an existing key stays ahead of an equal newcomer.
  function automatic logic better_eq(input logic [DATA_WIDTH-1:0] a,
                                     input logic [DATA_WIDTH-1:0] b);
    return (MAX_MODE != 0) ? (a >= b) : (a <= b);
  endfunction

  assign full    = (size_q == SW'(QUEUE_SIZE));
  assign empty   = (size_q == '0);
  assign o_full  = full;
  assign o_empty = empty;
  assign o_size  = size_q;
  assign o_data  = win_vld ? win_key : '0;

  // Command decode; replace on an empty queue degrades to a plain insert.
  assign do_deq  = !i_wrt && i_read && !empty;
  assign do_rep  = i_wrt && i_read && !empty;
  assign ins_new = (i_wrt && !i_read && !full) || (i_wrt && i_read && empty);

  // Level-0 selector: best valid head, lowest bank index on ties.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    win_key = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (cnt_q[k] != '0 && (!win_vld || better(ent_q[k][0], win_key))) begin
        win     = BW'(k);
        win_vld = 1'b1;
        win_key = ent_q[k][0];
      end
    end
  end

  // Insert target: least-occupied non-full bank, lowest index on ties.
  always_comb begin
    tgt     = '0;
    tgt_vld = 1'b0;
    tgt_cnt = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (cnt_q[k] != CW'(BANK_DEPTH) && (!tgt_vld || cnt_q[k] < tgt_cnt)) begin
        tgt     = BW'(k);
        tgt_vld = 1'b1;
        tgt_cnt = cnt_q[k];
      end
    end
  end

  // Per-bank next state: optional head removal, then sorted insert via compare vector.
  always_comb begin
    for (int k = 0; k < NUM_BANKS; k++) begin
      cnt_d[k] = cnt_q[k];
      for (int j = 0; j < BANK_DEPTH; j++) begin
        ent_d[k][j] = ent_q[k][j];
      end
    end
    for (int j = 0; j < BANK_DEPTH; j++) begin
      base[j] = '0;
    end
    base_cnt = '0;
    shift    = 1'b0;
    ins      = 1'b0;
    ge       = 1'b0;
    prev_ge  = 1'b0;
    prev_val = '0;

    for (int k = 0; k < NUM_BANKS; k++) begin
      shift = (do_deq || do_rep) && (win == BW'(k));
      ins   = (ins_new && (tgt == BW'(k))) || (do_rep && (win == BW'(k)));

      // Bank contents after the optional head removal.
      for (int j = 0; j < BANK_DEPTH - 1; j++) begin
        base[j] = shift ? ent_q[k][j+1] : ent_q[k][j];
      end
      base[BANK_DEPTH-1] = shift ? '0 : ent_q[k][BANK_DEPTH-1];
      base_cnt = shift ? (cnt_q[k] - CW'(1)) : cnt_q[k];

      // ge is a prefix of ones; the new key lands at the first zero.
      prev_ge  = 1'b1;
      prev_val = '0;
      for (int j = 0; j < BANK_DEPTH; j++) begin
        ge = (CW'(j) < base_cnt) && better_eq(base[j], i_data);
        if (!ins || ge) begin
          ent_d[k][j] = base[j];
        end else if (prev_ge) begin
          ent_d[k][j] = i_data;
        end else begin
          ent_d[k][j] = prev_val;
        end
        prev_ge  = ge;
        prev_val = base[j];
      end
      cnt_d[k] = base_cnt + CW'(ins);
    end
  end

  // Occupancy: replace leaves it unchanged; guards keep it from wrapping.
  always_comb begin
    size_d = size_q;
    if (ins_new) begin
      size_d = size_q + SW'(1);
    end else if (do_deq) begin
      size_d = size_q - SW'(1);
    end
  end

  // State registers with synchronous reset taking priority over commands.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < NUM_BANKS; k++) begin
        cnt_q[k] <= '0;
        for (int j = 0; j < BANK_DEPTH; j++) begin
          ent_q[k][j] <= '0;
        end
      end
      size_q <= '0;
    end else begin
      for (int k = 0; k < NUM_BANKS; k++) begin
        cnt_q[k] <= cnt_d[k];
        for (int j = 0; j < BANK_DEPTH; j++) begin
          ent_q[k][j] <= ent_d[k][j];
        end
      end
      size_q <= size_d;
    end
  end

`ifdef HPQ_ERR_EN
  logic [1:0] err_q;

  assign o_err = err_q;

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      err_q <= 2'b00;
    end else begin
      if (i_wrt && !i_read && full) begin
        err_q[0] <= 1'b1;
      end
      if (!i_wrt && i_read && empty) begin
        err_q[1] <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hybrid_banked_pq.sv
// tb_hybrid_banked_pq: directed and randomized checks of hybrid_banked_pq.
// A largest-first and a smallest-first instance share stimulus; each is compared
// every cycle against a multiset model of its queue.
module tb_hybrid_banked_pq;

  localparam int DW = 16;
  localparam int NB = 4;
  localparam int BD = 8;
  localparam int QS = NB * BD;
  localparam int SW = $clog2(QS + 1);

  logic          CLK = 1'b0;
  logic          RST;
  logic          i_wrt;
  logic          i_read;
  logic [DW-1:0] i_data;

  logic          mx_full, mx_empty, mn_full, mn_empty;
  logic [DW-1:0] mx_data, mn_data;
  logic [SW-1:0] mx_size, mn_size;
`ifdef HPQ_ERR_EN
  logic [1:0]    mx_err, mn_err;
`endif

  int checks   = 0;
  int failures = 0;

  // Model: index 0 = largest-first queue, 1 = smallest-first queue.
  logic [DW-1:0] mk [2][QS];
  int            mcnt [2];
  logic [1:0]    merr;

  always #5 CLK = ~CLK;

  hybrid_banked_pq #(
    .DATA_WIDTH(DW), .NUM_BANKS(NB), .BANK_DEPTH(BD), .MAX_MODE(1)
  ) dut_max (
    .CLK    (CLK),
    .RST    (RST),
    .i_wrt  (i_wrt),
    .i_read (i_read),
    .i_data (i_data),
    .o_full (mx_full),
    .o_empty(mx_empty),
    .o_data (mx_data),
    .o_size (mx_size)
`ifdef HPQ_ERR_EN
    ,
    .o_err  (mx_err)
`endif
  );

  hybrid_banked_pq #(
    .DATA_WIDTH(DW), .NUM_BANKS(NB), .BANK_DEPTH(BD), .MAX_MODE(0)
  ) dut_min (
    .CLK    (CLK),
    .RST    (RST),
    .i_wrt  (i_wrt),
    .i_read (i_read),
    .i_data (i_data),
    .o_full (mn_full),
    .o_empty(mn_empty),
    .o_data (mn_data),
    .o_size (mn_size)
`ifdef HPQ_ERR_EN
    ,
    .o_err  (mn_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int best_idx(input int m);
    int bi = 0;
    for (int i = 1; i < mcnt[m]; i++) begin
      if ((m == 0) ? (mk[m][i] > mk[m][bi]) : (mk[m][i] < mk[m][bi])) bi = i;
    end
    return bi;
  endfunction

  function automatic logic [DW-1:0] model_best(input int m);
    if (mcnt[m] == 0) return '0;
    return mk[m][best_idx(m)];
  endfunction

  task automatic model_cmd(input int m, input logic w, input logic r, input logic [DW-1:0] d);
    int bi;
    if (w && !r) begin
      if (mcnt[m] < QS) begin
        mk[m][mcnt[m]] = d;
        mcnt[m]++;
      end
    end else if (!w && r) begin
      if (mcnt[m] > 0) begin
        bi = best_idx(m);
        mk[m][bi] = mk[m][mcnt[m]-1];
        mcnt[m]--;
      end
    end else if (w && r) begin
      if (mcnt[m] > 0) begin
        mk[m][best_idx(m)] = d;
      end else begin
        mk[m][0] = d;
        mcnt[m] = 1;
      end
    end
  endtask

  task automatic compare_all();
    check("max_data",  32'(mx_data),  32'(model_best(0)));
    check("max_size",  32'(mx_size),  32'(mcnt[0]));
    check("max_full",  32'(mx_full),  32'(mcnt[0] == QS));
    check("max_empty", 32'(mx_empty), 32'(mcnt[0] == 0));
    check("min_data",  32'(mn_data),  32'(model_best(1)));
    check("min_size",  32'(mn_size),  32'(mcnt[1]));
`ifdef HPQ_ERR_EN
    check("max_err",   32'(mx_err),   32'(merr));
    check("min_err",   32'(mn_err),   32'(merr));
`endif
  endtask

  // Drive one command, advance one edge, update the model and compare.
  task automatic cycle(input logic rst, input logic w, input logic r, input logic [DW-1:0] d);
    RST    = rst;
    i_wrt  = w;
    i_read = r;
    i_data = d;
    @(posedge CLK);
    #1;
    if (rst) begin
      mcnt[0] = 0;
      mcnt[1] = 0;
      merr    = 2'b00;
    end else begin
      if (w && !r && mcnt[0] == QS) merr[0] = 1'b1;
      if (!w && r && mcnt[0] == 0)  merr[1] = 1'b1;
      model_cmd(0, w, r, d);
      model_cmd(1, w, r, d);
    end
    compare_all();
  endtask

  initial begin
    int pct;
    int wprob;
    logic [DW-1:0] key;
    logic [DW-1:0] pops [5];

    RST = 1'b1; i_wrt = 1'b1; i_read = 1'b0; i_data = '0;
    mcnt[0] = 0; mcnt[1] = 0; merr = 2'b00;

    // Reset with a pending write.
    cycle(1'b1, 1'b1, 1'b0, 16'h1234);
    cycle(1'b1, 1'b1, 1'b0, 16'h1234);
    check("rst_empty", 32'(mx_empty), 32'd1);
    check("rst_size",  32'(mx_size),  32'd0);
    check("rst_data",  32'(mx_data),  32'd0);
    check("rst_full",  32'(mx_full),  32'd0);

    // Largest-first ordering with duplicates.
    cycle(1'b0, 1'b1, 1'b0, 16'd5);
    cycle(1'b0, 1'b1, 1'b0, 16'd9);
    cycle(1'b0, 1'b1, 1'b0, 16'd3);
    cycle(1'b0, 1'b1, 1'b0, 16'd9);
    cycle(1'b0, 1'b1, 1'b0, 16'd1);
    check("enq5_data", 32'(mx_data), 32'd9);
    check("enq5_size", 32'(mx_size), 32'd5);
    pops = '{16'd9, 16'd9, 16'd5, 16'd3, 16'd1};
    for (int i = 0; i < 5; i++) begin
      check("pop_value", 32'(mx_data), 32'(pops[i]));
      cycle(1'b0, 1'b0, 1'b1, '0);
    end
    check("pop_empty", 32'(mx_empty), 32'd1);

    // Bank balance and fill to capacity.
    cycle(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, 16'(i * 3 + 1));
    for (int k = 0; k < NB; k++) check("bank_cnt", 32'(dut_max.cnt_q[k]), 32'd2);
    for (int i = 8; i < QS; i++) cycle(1'b0, 1'b1, 1'b0, 16'(i * 3 + 1));
    check("fill_full", 32'(mx_full), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 16'hFFFF);
    check("ovf_data", 32'(mx_data), 32'd94);
    check("ovf_size", 32'(mx_size), 32'(QS));
`ifdef HPQ_ERR_EN
    check("ovf_flag", 32'(mx_err[0]), 32'd1);
`endif

    // Replace semantics.
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b0, 16'd7);
    cycle(1'b0, 1'b1, 1'b0, 16'd4);
    cycle(1'b0, 1'b1, 1'b0, 16'd2);
    check("rep_popped", 32'(mx_data), 32'd7);
    cycle(1'b0, 1'b1, 1'b1, 16'd6);
    check("rep6_data", 32'(mx_data), 32'd6);
    check("rep6_size", 32'(mx_size), 32'd3);
    cycle(1'b0, 1'b1, 1'b1, 16'd1);
    check("rep1_data", 32'(mx_data), 32'd4);
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b1, 16'd0);
    check("rep_empty_size", 32'(mx_size), 32'd1);
    check("rep_empty_data", 32'(mx_data), 32'd0);

    // Dequeue on empty.
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b1, '0);
    check("udf_size",  32'(mx_size),  32'd0);
    check("udf_empty", 32'(mx_empty), 32'd1);
`ifdef HPQ_ERR_EN
    check("udf_flag", 32'(mx_err[1]), 32'd1);
`endif

    // Random mix in phases that alternately fill and drain.
    cycle(1'b1, 1'b0, 1'b0, '0);
    for (int n = 0; n < 1000; n++) begin
      wprob = ((n / 100) % 2 == 0) ? 75 : 35;
      pct = $urandom_range(0, 99);
      key = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), key);
      end else if (pct < 10) begin
        cycle(1'b0, 1'b0, 1'b0, key);
      end else if (pct < 25) begin
        cycle(1'b0, 1'b1, 1'b1, key);
      end else if ($urandom_range(0, 99) < wprob) begin
        cycle(1'b0, 1'b1, 1'b0, key);
      end else begin
        cycle(1'b0, 1'b0, 1'b1, key);
      end
    end

    // Mid-stream reset empties the queue on the next cycle.
    cycle(1'b0, 1'b1, 1'b0, 16'd42);
    cycle(1'b1, 1'b1, 1'b0, 16'd43);
    check("mid_rst_empty", 32'(mn_empty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
